// File: rtl/sfx_sequencer.sv
// -----------------------------------------------------------------------------
// sfx_sequencer
//   Turns single-cycle game-event strobes (attack, hit, death) into
//   frame-timed level triggers for the APU's square/noise/saw inputs.
//   Simultaneous strobes are arbitrated by priority: death > hit > attack.
//   A strobe with priority equal to or higher than the current sound restarts
//   or retriggers it. Frame timing is derived from the same x/y scan counters
//   that the APU sees.
//
//   Build option: define SFX_QUEUE_EN to enable a 1-deep pending slot. The slot
//   holds a lower-priority event that arrives while a sound is playing. When
//   the current sound expires, one silent frame (GAP) is inserted before the
//   pending sound starts. Without the macro, lower-priority events are dropped
//   and GAP is never entered.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   evt_attack      1-cycle strobe, priority 0 -> square_trigger
//   evt_hit         1-cycle strobe, priority 1 -> noise_trigger
//   evt_death       1-cycle strobe, priority 2 -> saw_trigger
//   x, y            scan position (10 bits each)
//   saw_trigger     registered level to the APU
//   square_trigger  registered level to the APU
//   noise_trigger   registered level to the APU
//   busy            registered, high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module sfx_sequencer #(
  parameter int ATTACK_FRAMES = 6,
  parameter int HIT_FRAMES    = 10,
  parameter int DEATH_FRAMES  = 30,
  parameter int FRAME_LINE    = 480,
  parameter int CNT_W         = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       evt_attack,
  input  logic       evt_hit,
  input  logic       evt_death,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       saw_trigger,
  output logic       square_trigger,
  output logic       noise_trigger,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Sound identifiers equal their arbitration priority, so a numeric compare
  // is a priority compare.
  localparam logic [1:0] P_ATTACK = 2'd0;
  localparam logic [1:0] P_HIT    = 2'd1;
  localparam logic [1:0] P_DEATH  = 2'd2;

  localparam logic [9:0]       FRAME_Y = 10'(FRAME_LINE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A configured duration of 0 frames is treated as 1 frame.
  function automatic logic [CNT_W-1:0] duration(input logic [1:0] pri);
    int unsigned d;
    case (pri)
      P_DEATH: d = DEATH_FRAMES;
      P_HIT:   d = HIT_FRAMES;
      default: d = ATTACK_FRAMES;
    endcase
    if (d == 0) d = 1;
    return d[CNT_W-1:0];
  endfunction

  logic             match;
  logic             match_q;
  logic             frame_tick;
  logic [1:0]       state, state_n;
  logic [1:0]       cur, cur_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pend_valid, pend_valid_n;
  logic [1:0]       pend_pri, pend_pri_n;
  logic             evt_valid;
  logic [1:0]       evt_pri;

  assign match     = (x == 10'd0) && (y == FRAME_Y);
  assign evt_valid = evt_attack | evt_hit | evt_death;
  assign evt_pri   = evt_death ? P_DEATH : (evt_hit ? P_HIT : P_ATTACK);

  // Frame tick: one-cycle pulse on the cycle after match rises, so a match
  // held across several clocks still counts as a single frame.
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      match_q    <= match;
      frame_tick <= match & ~match_q;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_n      = state;
    cur_n        = cur;
    cnt_n        = cnt;
    pend_valid_n = pend_valid;
    pend_pri_n   = pend_pri;

    case (state)
      S_IDLE: begin
        if (evt_valid) begin
          state_n = S_PLAY;
          cur_n   = evt_pri;
          cnt_n   = duration(evt_pri);
        end
      end

      S_PLAY: begin
        if (evt_valid && (evt_pri >= cur)) begin
          // Restart or retrigger; wins over an expiry on the same cycle.
          cur_n = evt_pri;
          cnt_n = duration(evt_pri);
        end else begin
`ifdef SFX_QUEUE_EN
          if (evt_valid && (!pend_valid || (evt_pri >= pend_pri))) begin
            pend_valid_n = 1'b1;
            pend_pri_n   = evt_pri;
          end
`endif
          if (frame_tick) begin
            if (cnt == CNT_ONE) begin
              // An event queued on this very cycle already counts as pending.
              state_n = pend_valid_n ? S_GAP : S_IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt - CNT_ONE;
            end
          end
        end
      end

      S_GAP: begin
        if (evt_valid) begin
          state_n = S_PLAY;
          cur_n   = evt_pri;
          cnt_n   = duration(evt_pri);
          if (pend_pri <= evt_pri) pend_valid_n = 1'b0;
        end else if (frame_tick) begin
          state_n      = S_PLAY;
          cur_n        = pend_pri;
          cnt_n        = duration(pend_pri);
          pend_valid_n = 1'b0;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it, so a
  // trigger rises on the cycle after the accepted strobe and only one trigger
  // can be high at a time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cur            <= P_ATTACK;
      cnt            <= '0;
      pend_valid     <= 1'b0;
      pend_pri       <= P_ATTACK;
      saw_trigger    <= 1'b0;
      square_trigger <= 1'b0;
      noise_trigger  <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      cur            <= cur_n;
      cnt            <= cnt_n;
      pend_valid     <= pend_valid_n;
      pend_pri       <= pend_pri_n;
      saw_trigger    <= (state_n == S_PLAY) && (cur_n == P_DEATH);
      square_trigger <= (state_n == S_PLAY) && (cur_n == P_ATTACK);
      noise_trigger  <= (state_n == S_PLAY) && (cur_n == P_HIT);
      busy           <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sfx_sequencer
//   Directed scenarios followed by a randomized phase. Expected outputs come
//   from a behavioural model that tracks "which sound is playing, how many
//   frames remain, what is waiting" in plain integers.
//   Define SFX_QUEUE_EN for both bench and RTL to exercise the pending slot.
// -----------------------------------------------------------------------------
module tb_sfx_sequencer;

`ifdef SFX_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       evt_attack, evt_hit, evt_death;
  logic [9:0] x, y;
  logic       saw_trigger, square_trigger, noise_trigger, busy;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  // Behavioural model: sound id 0 = attack/square, 1 = hit/noise,
  // 2 = death/saw, -1 = nothing.
  int m_cur  = -1;
  int m_left = 0;
  int m_pend = -1;
  bit m_gap  = 1'b0;
  bit m_tick = 1'b0;
  bit m_prev_match = 1'b0;

  sfx_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .evt_attack     (evt_attack),
    .evt_hit        (evt_hit),
    .evt_death      (evt_death),
    .x              (x),
    .y              (y),
    .saw_trigger    (saw_trigger),
    .square_trigger (square_trigger),
    .noise_trigger  (noise_trigger),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic int frames_of(input int id);
    case (id)
      2:       return 30;
      1:       return 10;
      default: return 6;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1; m_left = 0; m_pend = -1; m_gap = 1'b0;
    m_tick = 1'b0; m_prev_match = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    int ev;
    bit tk;
    bit mt;
    ev = evt_death ? 2 : (evt_hit ? 1 : (evt_attack ? 0 : -1));
    tk = m_tick;
    mt = (x == 10'd0) && (y == 10'd480);
    m_tick = mt && !m_prev_match;
    m_prev_match = mt;
    if (m_gap) begin
      if (ev >= 0) begin
        if (m_pend <= ev) m_pend = -1;
        m_gap = 1'b0; m_cur = ev; m_left = frames_of(ev);
      end else if (tk) begin
        m_gap = 1'b0; m_cur = m_pend; m_left = frames_of(m_pend); m_pend = -1;
      end
    end else if (m_cur >= 0) begin
      if (ev >= m_cur) begin
        m_cur = ev; m_left = frames_of(ev);
      end else begin
        if (QUEUE && ev >= 0 && ev >= m_pend) m_pend = ev;
        if (tk) begin
          m_left--;
          if (m_left == 0) begin
            m_cur = -1;
            if (m_pend >= 0) m_gap = 1'b1;
          end
        end
      end
    end else if (ev >= 0) begin
      m_cur = ev; m_left = frames_of(ev);
    end
  endtask

  task automatic compare(input string where);
    check({where, ".saw"},    saw_trigger,    !m_gap && m_cur == 2);
    check({where, ".square"}, square_trigger, !m_gap && m_cur == 0);
    check({where, ".noise"},  noise_trigger,  !m_gap && m_cur == 1);
    check({where, ".busy"},   busy,           m_gap || m_cur >= 0);
    check({where, ".onehot"}, ($countones({saw_trigger, square_trigger, noise_trigger}) <= 1), 1);
  endtask

  task automatic cyc(input string where);
    @(posedge clk);
    model_step();
    #1;
    if (dut.frame_tick) tick_cnt++;
    compare(where);
    evt_attack = 1'b0; evt_hit = 1'b0; evt_death = 1'b0;
  endtask

  // Hold match for `hold` clocks, then idle long enough for the tick to land.
  task automatic frame_pulse(input int hold, input string where);
    x = 10'd0; y = 10'd480;
    repeat (hold) cyc(where);
    x = 10'd5; y = 10'd0;
    repeat (2) cyc(where);
  endtask

  task automatic frames(input int n, input string where);
    repeat (n) frame_pulse(1, where);
  endtask

  task automatic strobe(input bit a, input bit h, input bit d, input string where);
    evt_attack = a; evt_hit = h; evt_death = d;
    cyc(where);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    evt_attack = 1'b0; evt_hit = 1'b0; evt_death = 1'b0;
    x = 10'd5; y = 10'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare("reset");
    @(negedge clk);
    reset = 1'b0;
    cyc("idle");

    // 1: attack -> square for 6 frames
    strobe(1, 0, 0, "t1_strobe");
    check("t1_square_up", square_trigger, 1);
    check("t1_busy_up", busy, 1);
    frames(5, "t1_play");
    check("t1_square_5", square_trigger, 1);
    frames(1, "t1_end");
    check("t1_square_6", square_trigger, 0);
    check("t1_busy_6", busy, 0);

    // 2: match held 5 clocks -> one tick; death -> 30 frames of saw
    tick_cnt = 0;
    frame_pulse(5, "t2_hold");
    check("t2_one_tick", tick_cnt, 1);
    strobe(0, 0, 1, "t2_strobe");
    n = 0;
    while (saw_trigger && n < 40) begin
      frame_pulse(1, "t2_play");
      n++;
    end
    check("t2_saw_frames", n, 30);

    // 3: hit preempts attack; noise lasts 10 frames from preemption
    strobe(1, 0, 0, "t3_attack");
    frames(2, "t3_attack_play");
    strobe(0, 1, 0, "t3_hit");
    check("t3_square_drop", square_trigger, 0);
    check("t3_noise_up", noise_trigger, 1);
    frames(9, "t3_noise_play");
    check("t3_noise_9", noise_trigger, 1);
    frames(1, "t3_noise_end");
    check("t3_noise_10", noise_trigger, 0);

    // 4: all three together -> only saw, then idle after 30 frames
    strobe(1, 1, 1, "t4_strobe");
    check("t4_saw", saw_trigger, 1);
    check("t4_square", square_trigger, 0);
    check("t4_noise", noise_trigger, 0);
    frames(30, "t4_play");
    check("t4_idle", busy, 0);

    // 5: attack during death -> queued (optional) after one silent frame
    strobe(0, 0, 1, "t5_death");
    frames(2, "t5_death_play");
    strobe(1, 0, 0, "t5_attack");
    check("t5_saw_kept", saw_trigger, 1);
    frames(28, "t5_death_play2");
    check("t5_gap_silent", square_trigger | saw_trigger, 0);
    check("t5_gap_busy", busy, QUEUE);
    frames(1, "t5_gap");
    check("t5_square_after_gap", square_trigger, QUEUE);
    frames(6, "t5_drain");
    check("t5_idle", busy, 0);

    // 6: asynchronous reset in the middle of a hit
    strobe(0, 1, 0, "t6_hit");
    frames(3, "t6_play");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare("t6_async_reset");
    @(negedge clk);
    reset = 1'b0;
    cyc("t6_release");
    strobe(1, 0, 0, "t6_attack");
    check("t6_square_up", square_trigger, 1);
    frames(6, "t6_play_attack");
    check("t6_idle", busy, 0);

    // Randomized phase: sparse strobes, frequent and sometimes held matches.
    repeat (3000) begin
      x = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'd1;
      y = ($urandom_range(0, 3) == 0) ? 10'd480 : 10'd100;
      evt_attack = ($urandom_range(0, 15) == 0);
      evt_hit    = ($urandom_range(0, 15) == 0);
      evt_death  = ($urandom_range(0, 23) == 0);
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
